axi_lite_tl_adapter: RTL and testbench

AXI-lite device to TileLink-UL host bridge, the inverse of tl_axi_lite_adapter. It lets AXI-lite masters, such as Xilinx IP DMA or debug cores, reach the TileLink fabric. The bridge keeps exactly one TileLink transaction outstanding and arbitrates between the AXI-lite read and write paths. It sits in the clk_i domain, behind any AXI clock converter.

---
 rtl/axi_lite_tl_adapter.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_tl_adapter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_tl_adapter.sv
// AXI-lite device to TileLink-UL host bridge. One TileLink transaction is in flight
// at a time, and the AXI read and write paths take turns in round-robin order.
module axi_lite_tl_adapter #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 13,
    parameter int unsigned SourceWidth = 1,
    parameter int unsigned SinkWidth   = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    device_aw_valid,
    output logic                                    device_aw_ready,
    input  logic [AddrWidth+2:0]                    device_aw,
    input  logic                                    device_w_valid,
    output logic                                    device_w_ready,
    input  logic [DataWidth+DataWidth/8-1:0]        device_w,
    output logic                                    device_b_valid,
    input  logic                                    device_b_ready,
    output logic [1:0]                              device_b,
    input  logic                                    device_ar_valid,
    output logic                                    device_ar_ready,
    input  logic [AddrWidth+2:0]                    device_ar,
    output logic                                    device_r_valid,
    input  logic                                    device_r_ready,
    output logic [DataWidth+1:0]                    device_r,
    output logic                                    host_a_valid,
    input  logic                                    host_a_ready,
    // A: {opcode[2:0], param[2:0], size[1:0], source, address, mask, corrupt, data}
    output logic [9+SourceWidth+AddrWidth+DataWidth/8+DataWidth-1:0] host_a,
    input  logic                                    host_d_valid,
    output logic                                    host_d_ready,
    // D: {opcode[2:0], param[2:0], size[1:0], source, sink, denied, corrupt, data}
    input  logic [10+SourceWidth+SinkWidth+DataWidth-1:0] host_d
);

    localparam int unsigned StrbW  = DataWidth / 8;
    localparam int unsigned AlignW = $clog2(StrbW);
    localparam int unsigned HdW    = 10 + SourceWidth + SinkWidth + DataWidth;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAckData    = 3'd1;
    localparam logic [1:0] RespOkay     = 2'b00;
    localparam logic [1:0] RespSlverr   = 2'b10;

    typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT, RESP} state_e;

    state_e                 state_q, state_d;
    logic                   run_q;
    logic                   rd_first_q, rd_first_d;
    logic                   is_read_q, is_read_d;
    logic                   a_valid_q, a_valid_d;
    logic [2:0]             a_opcode_q, a_opcode_d;
    logic [1:0]             a_size_q, a_size_d;
    logic [AddrWidth-1:0]   a_addr_q, a_addr_d;
    logic [StrbW-1:0]       a_mask_q, a_mask_d;
    logic [DataWidth-1:0]   a_data_q, a_data_d;
    logic                   d_ready_q, d_ready_d;
    logic                   b_valid_q, b_valid_d;
    logic [1:0]             b_resp_q, b_resp_d;
    logic                   r_valid_q, r_valid_d;
    logic [DataWidth-1:0]   r_data_q, r_data_d;
    logic [1:0]             r_resp_q, r_resp_d;

    logic                   wr_pend, grant_rd, grant_wr, d_err;
    logic [AddrWidth-1:0]   aw_addr, ar_addr;
    logic [DataWidth-1:0]   w_data, d_data;
    logic [StrbW-1:0]       w_strb;
    logic [2:0]             d_opcode;
    logic                   d_denied, d_corrupt;
    logic                   unused_bits;

    assign aw_addr   = device_aw[AddrWidth+2:3];
    assign ar_addr   = device_ar[AddrWidth+2:3];
    assign w_data    = device_w[DataWidth+StrbW-1:StrbW];
    assign w_strb    = device_w[StrbW-1:0];
    assign d_opcode  = host_d[HdW-1 -: 3];
    assign d_denied  = host_d[DataWidth+1];
    assign d_corrupt = host_d[DataWidth];
    assign d_data    = host_d[DataWidth-1:0];
    assign d_err     = d_denied | ((d_opcode == OpAckData) & d_corrupt);
    assign unused_bits = ^{device_aw[2:0], device_ar[2:0], host_d[HdW-4:DataWidth+2]};

    // run_q keeps every ready low while reset is held and for the first cycle after it
    always_comb begin
        wr_pend  = device_aw_valid & device_w_valid;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == IDLE && run_q) begin
            grant_rd = device_ar_valid & (rd_first_q | ~wr_pend);
            grant_wr = wr_pend & (~rd_first_q | ~device_ar_valid);
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_first_d = rd_first_q;
        is_read_d  = is_read_q;
        a_valid_d  = a_valid_q;
        a_opcode_d = a_opcode_q;
        a_size_d   = a_size_q;
        a_addr_d   = a_addr_q;
        a_mask_d   = a_mask_q;
        a_data_d   = a_data_q;
        d_ready_d  = d_ready_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    is_read_d  = 1'b1;
                    rd_first_d = ~rd_first_q;
                    a_valid_d  = 1'b1;
                    a_opcode_d = OpGet;
                    a_size_d   = 2'(AlignW);
                    a_addr_d   = ar_addr & ~AddrWidth'(StrbW - 1);
                    a_mask_d   = '1;
                    a_data_d   = '0;
                    state_d    = A_REQ;
                end else if (grant_wr) begin
                    is_read_d  = 1'b0;
                    rd_first_d = ~rd_first_q;
                    if (w_strb == '0) begin
                        b_valid_d = 1'b1;
                        b_resp_d  = RespOkay;
                        state_d   = RESP;
                    end else begin
                        a_valid_d  = 1'b1;
                        a_opcode_d = (w_strb == '1) ? OpPutFull : OpPutPartial;
                        a_size_d   = 2'(AlignW);
                        a_addr_d   = aw_addr & ~AddrWidth'(StrbW - 1);
                        a_mask_d   = w_strb;
                        a_data_d   = w_data;
                        state_d    = A_REQ;
                    end
                end
            end
            A_REQ: begin
                if (host_a_ready) begin
                    a_valid_d = 1'b0;
                    d_ready_d = 1'b1;
                    state_d   = D_WAIT;
                end
            end
            D_WAIT: begin
                if (host_d_valid) begin
                    d_ready_d = 1'b0;
                    state_d   = RESP;
                    if (is_read_q) begin
                        r_valid_d = 1'b1;
                        r_data_d  = d_data;
                        r_resp_d  = d_err ? RespSlverr : RespOkay;
                    end else begin
                        b_valid_d = 1'b1;
                        b_resp_d  = d_err ? RespSlverr : RespOkay;
                    end
                end
            end
            RESP: begin
                if (is_read_q && device_r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end else if (!is_read_q && device_b_ready) begin
                    b_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            rd_first_q <= 1'b1;
            is_read_q  <= 1'b0;
            a_valid_q  <= 1'b0;
            a_opcode_q <= '0;
            a_size_q   <= '0;
            a_addr_q   <= '0;
            a_mask_q   <= '0;
            a_data_q   <= '0;
            d_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            rd_first_q <= rd_first_d;
            is_read_q  <= is_read_d;
            a_valid_q  <= a_valid_d;
            a_opcode_q <= a_opcode_d;
            a_size_q   <= a_size_d;
            a_addr_q   <= a_addr_d;
            a_mask_q   <= a_mask_d;
            a_data_q   <= a_data_d;
            d_ready_q  <= d_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign device_ar_ready = grant_rd;
    assign device_aw_ready = grant_wr;
    assign device_w_ready  = grant_wr;
    assign device_b_valid  = b_valid_q;
    assign device_b        = b_resp_q;
    assign device_r_valid  = r_valid_q;
    assign device_r        = {r_data_q, r_resp_q};
    assign host_a_valid    = a_valid_q;
    assign host_a          = {a_opcode_q, 3'b000, a_size_q, {SourceWidth{1'b0}},
                              a_addr_q, a_mask_q, 1'b0, a_data_q};
    assign host_d_ready    = d_ready_q;

endmodule

// File: tb/tb_axi_lite_tl_adapter.sv
// Randomized self-checking bench for axi_lite_tl_adapter: directed cases first, then
// random read/write traffic checked against a rule-level model of the bridge.
module tb_axi_lite_tl_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [15:0] aw = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [35:0] w = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b;
    logic        ar_valid = 1'b0, ar_ready;
    logic [15:0] ar = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [33:0] r;
    logic        a_valid, a_ready = 1'b0;
    logic [58:0] host_a;
    logic        d_valid = 1'b0, d_ready;
    logic [43:0] host_d = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // model state: round-robin flag and the requests currently presented
    bit          rd_first = 1'b1;
    bit          last_rd;
    int unsigned last_wait;
    logic [12:0] rq_rd_addr, rq_wr_addr;
    logic [31:0] rq_wr_data;
    logic [3:0]  rq_wr_strb;

    always #5 clk = ~clk;

    axi_lite_tl_adapter #(
        .DataWidth  (32),
        .AddrWidth  (13),
        .SourceWidth(1),
        .SinkWidth  (1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .device_aw_valid(aw_valid),
        .device_aw_ready(aw_ready),
        .device_aw      (aw),
        .device_w_valid (w_valid),
        .device_w_ready (w_ready),
        .device_w       (w),
        .device_b_valid (b_valid),
        .device_b_ready (b_ready),
        .device_b       (b),
        .device_ar_valid(ar_valid),
        .device_ar_ready(ar_ready),
        .device_ar      (ar),
        .device_r_valid (r_valid),
        .device_r_ready (r_ready),
        .device_r       (r),
        .host_a_valid   (a_valid),
        .host_a_ready   (a_ready),
        .host_a         (host_a),
        .host_d_valid   (d_valid),
        .host_d_ready   (d_ready),
        .host_d         (host_d)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_read(input logic [12:0] addr);
        rq_rd_addr = addr;
        ar         = {addr, 3'($urandom_range(7))};
        ar_valid   = 1'b1;
    endtask

    task automatic start_write(input logic [12:0] addr, input logic [31:0] data, input logic [3:0] strb);
        rq_wr_addr = addr;
        rq_wr_data = data;
        rq_wr_strb = strb;
        aw         = {addr, 3'($urandom_range(7))};
        w          = {data, strb};
        aw_valid   = 1'b1;
        w_valid    = 1'b1;
    endtask

    // Called at posedge+1 with requests presented; runs one whole transaction.
    task automatic serve(input int unsigned a_stall, input int unsigned r_stall,
                         input bit den, input bit cor, input logic [31:0] ddata);
        bit          got_grant = 1'b0;
        bit          exp_rd, skip_a;
        logic [2:0]  exp_op;
        logic [3:0]  exp_mask;
        logic [12:0] exp_addr;
        logic [1:0]  exp_resp;
        exp_rd    = ar_valid && (!(aw_valid && w_valid) || rd_first);
        last_wait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ar_ready || aw_ready || w_ready) begin
                got_grant = 1'b1;
                break;
            end
            last_wait++;
        end
        check_eq("grant_seen", got_grant, 1);
        if (!got_grant) begin
            ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check_eq("ar_ready", ar_ready, exp_rd);
        check_eq("aw_ready", aw_ready, !exp_rd);
        check_eq("w_ready", w_ready, !exp_rd);
        rd_first = !rd_first;
        last_rd  = exp_rd;
        exp_addr = (exp_rd ? rq_rd_addr : rq_wr_addr) & 13'h1FFC;
        exp_mask = exp_rd ? 4'hF : rq_wr_strb;
        exp_op   = exp_rd ? 3'd4 : ((rq_wr_strb == 4'hF) ? 3'd0 : 3'd1);
        skip_a   = !exp_rd && (rq_wr_strb == 4'h0);
        exp_resp = (!skip_a && (den || (exp_rd && cor))) ? 2'b10 : 2'b00;
        @(posedge clk); #1;
        if (exp_rd) ar_valid = 1'b0;
        else begin aw_valid = 1'b0; w_valid = 1'b0; end
        if (!skip_a) begin
            a_ready = (a_stall == 0);
            for (int k = 0; k <= int'(a_stall); k++) begin
                @(negedge clk);
                check_eq("a_valid", a_valid, 1);
                check_eq("a_opcode", host_a[58:56], exp_op);
                check_eq("a_addr", host_a[49:37], exp_addr);
                check_eq("a_mask", host_a[36:33], exp_mask);
                check_eq("a_size", host_a[52:51], 2);
                check_eq("a_fixed", {host_a[55:53], host_a[50], host_a[32]}, 0);
                if (!exp_rd) check_eq("a_data", host_a[31:0], rq_wr_data);
                check_eq("a_phase_idle", {ar_ready, aw_ready, w_ready, d_ready}, 0);
                @(posedge clk); #1;
                a_ready = (k + 1 == int'(a_stall));
            end
            host_d  = {(exp_rd ? 3'd1 : 3'd0), 3'($urandom_range(7)), 2'd2,
                       1'($urandom_range(1)), 1'($urandom_range(1)), den, cor, ddata};
            d_valid = 1'b1;
            @(negedge clk);
            check_eq("d_ready", d_ready, 1);
            @(posedge clk); #1;
            d_valid = 1'b0;
        end
        if (exp_rd) r_ready = (r_stall == 0);
        else        b_ready = (r_stall == 0);
        for (int k = 0; k <= int'(r_stall); k++) begin
            @(negedge clk);
            if (exp_rd) begin
                check_eq("r_valid", {r_valid, b_valid}, 2'b10);
                check_eq("r_data", r[33:2], ddata);
                check_eq("r_resp", r[1:0], exp_resp);
            end else begin
                check_eq("b_valid", {b_valid, r_valid}, 2'b10);
                check_eq("b_resp", b, exp_resp);
            end
            check_eq("resp_phase_idle", {ar_ready, aw_ready, w_ready, a_valid, d_ready}, 0);
            @(posedge clk); #1;
            if (exp_rd) r_ready = (k + 1 == int'(r_stall));
            else        b_ready = (k + 1 == int'(r_stall));
        end
        check_eq("resp_drop", {r_valid, b_valid}, 0);
    endtask

    initial begin
        logic [3:0] strb;
        // reset state, with requests presented so a combinational ready would show
        ar_valid = 1'b1; aw_valid = 1'b1; w_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_handshakes", {aw_ready, w_ready, b_valid, ar_ready, r_valid, a_valid, d_ready}, 0);
        check_eq("rst_host_a", host_a, 0);
        check_eq("rst_payloads", {r, b}, 0);
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_read(13'h0104);
        serve(0, 0, 1'b0, 1'b0, 32'hDEADBEEF);
        check_eq("min_latency_grant", last_wait, 0);
        start_write(13'h0008, 32'h11223344, 4'hF);
        serve(0, 0, 1'b0, 1'b0, 32'h0);
        start_write(13'h0008, 32'h11223344, 4'h6);
        serve(0, 0, 1'b0, 1'b1, 32'h0);
        start_write(13'h0013, 32'hCAFEF00D, 4'h0);
        serve(0, 0, 1'b0, 1'b0, 32'h0);
        start_read(13'h0040);
        serve(0, 0, 1'b1, 1'b0, 32'h01234567);
        start_read(13'h0044);
        serve(0, 0, 1'b0, 1'b1, 32'h5A5A5A5A);
        start_read(13'h1FFF);
        serve(5, 3, 1'b0, 1'b0, 32'h89ABCDEF);

        // AW without W is held off while a read goes through
        start_write(13'h0200, 32'hA5A55A5A, 4'h3);
        w_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("aw_alone_held", {aw_ready, w_ready}, 0);
            @(posedge clk); #1;
        end
        start_read(13'h0300);
        serve(0, 0, 1'b0, 1'b0, 32'h0BADF00D);
        w_valid = 1'b1;
        serve(1, 1, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 60; n++) begin
            if (!ar_valid && $urandom_range(0, 2) != 0) start_read(13'($urandom));
            if (!aw_valid && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 5))
                    0:       strb = 4'h0;
                    1, 2:    strb = 4'hF;
                    default: strb = 4'($urandom);
                endcase
                start_write(13'($urandom), $urandom, strb);
            end
            if (!ar_valid && !aw_valid) start_read(13'($urandom));
            serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom);
        end
        while (ar_valid || aw_valid) serve(0, 0, 1'b0, 1'b0, $urandom);

        // reset while waiting on D drops everything in the same cycle
        start_read(13'h0500);
        for (int i = 0; i < 20 && !ar_ready; i++) begin
            @(negedge clk);
            if (ar_ready) break;
            @(posedge clk); #1;
        end
        check_eq("pre_reset_grant", ar_ready, 1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        a_ready  = 1'b1;
        @(posedge clk); #1;
        a_ready = 1'b0;
        @(negedge clk);
        check_eq("d_wait_ready", d_ready, 1);
        start_read(13'h0600);
        start_write(13'h0604, 32'h76543210, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_handshakes", {aw_ready, w_ready, b_valid, ar_ready, r_valid, a_valid, d_ready}, 0);
        check_eq("mid_rst_host_a", host_a, 0);
        rd_first = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // both paths held continuously: grants alternate starting with the read
        for (int n = 0; n < 6; n++) begin
            serve(0, 0, 1'b0, 1'b0, $urandom);
            check_eq("alt_order", last_rd, (n % 2) == 0);
            if (n > 0) check_eq("back_to_back", last_wait, 0);
            if (last_rd) start_read(13'($urandom));
            else         start_write(13'($urandom), $urandom, 4'hF);
        end
        while (ar_valid || aw_valid) serve(0, 0, 1'b0, 1'b0, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
